// File: rtl/rx_reg_bridge.sv
// Byte-stream to register-bus bridge: parses SYNC/CMD/ADDR/COUNT packets into
// burst register writes, or into burst reads streamed back LSB first.
module rx_reg_bridge #(
   parameter int          DATA_BYTES = 4,
   parameter int          ADDR_WIDTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
   input  logic                    ipClk,
   input  logic                    reset,
   input  logic [7:0]              ipRxData,
   input  logic                    ipRxValid,
   output logic                    opRxReady,
   output logic [ADDR_WIDTH-1:0]   opAddress,
   output logic [8*DATA_BYTES-1:0] opWrData,
   output logic                    opWrEnable,
   output logic                    opRdEnable,
   input  logic [8*DATA_BYTES-1:0] ipRdData,
   output logic [7:0]              opTxData,
   output logic                    opTxValid,
   input  logic                    ipTxReady
);

   localparam int DW         = 8 * DATA_BYTES;
   localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int AW_PAD     = 8 * ADDR_BYTES;
   localparam int IDXW       = $clog2(DATA_BYTES + 1);

   typedef enum logic [3:0] {
      IDLE,
      GET_CMD,
      GET_ADDR,
      GET_COUNT,
      GET_DATA,
      WR_PULSE,
      RD_REQ,
      RD_WAIT,
      SEND
   } state_t;

   state_t                state_q, state_d;
   logic                  is_write_q, is_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]         wr_data_q, wr_data_d;
   logic [DW-1:0]         rd_buf_q, rd_buf_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [IDXW-1:0]       byte_idx_q, byte_idx_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;

   logic                  beat;
   logic [IDXW+2:0]       shamt;
   logic [AW_PAD-1:0]     addr_pad;

   always_comb begin
      state_d     = state_q;
      is_write_d  = is_write_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      rd_buf_d    = rd_buf_q;
      remaining_d = remaining_q;
      byte_idx_d  = byte_idx_q;
      tx_data_d   = tx_data_q;

      beat  = ipRxValid && rx_ready_q;
      shamt = {byte_idx_q, 3'b000};
      // Multi-byte fields are merged one byte lane at a time, LSB first
      addr_pad = AW_PAD'(addr_q);
      addr_pad = (addr_pad & ~(AW_PAD'(8'hFF) << shamt)) | (AW_PAD'(ipRxData) << shamt);

      case (state_q)
         IDLE: begin
            if (beat && ipRxData == SYNC_BYTE) state_d = GET_CMD;
         end
         GET_CMD: begin
            if (beat) begin
               byte_idx_d = '0;
               if (ipRxData == 8'h01) begin
                  is_write_d = 1'b1;
                  state_d    = GET_ADDR;
               end else if (ipRxData == 8'h00) begin
                  is_write_d = 1'b0;
                  state_d    = GET_ADDR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GET_ADDR: begin
            if (beat) begin
               addr_d = addr_pad[ADDR_WIDTH-1:0];
               if (byte_idx_q == IDXW'(ADDR_BYTES - 1)) begin
                  byte_idx_d = '0;
                  state_d    = GET_COUNT;
               end else begin
                  byte_idx_d = byte_idx_q + IDXW'(1);
               end
            end
         end
         GET_COUNT: begin
            if (beat) begin
               remaining_d = ipRxData;
               byte_idx_d  = '0;
               if (ipRxData == 8'h00)  state_d = IDLE;
               else if (is_write_q)    state_d = GET_DATA;
               else                    state_d = RD_REQ;
            end
         end
         GET_DATA: begin
            if (beat) begin
               wr_data_d = (wr_data_q & ~(DW'(8'hFF) << shamt)) | (DW'(ipRxData) << shamt);
               if (byte_idx_q == IDXW'(DATA_BYTES - 1)) begin
                  byte_idx_d = '0;
                  state_d    = WR_PULSE;
               end else begin
                  byte_idx_d = byte_idx_q + IDXW'(1);
               end
            end
         end
         WR_PULSE: begin
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - 8'd1;
            state_d     = (remaining_q == 8'd1) ? IDLE : GET_DATA;
         end
         RD_REQ: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            rd_buf_d   = ipRdData;
            tx_data_d  = ipRdData[7:0];
            byte_idx_d = '0;
            state_d    = SEND;
         end
         SEND: begin
            if (tx_valid_q && ipTxReady) begin
               if (byte_idx_q == IDXW'(DATA_BYTES - 1)) begin
                  byte_idx_d  = '0;
                  addr_d      = addr_q + ADDR_WIDTH'(1);
                  remaining_d = remaining_q - 8'd1;
                  state_d     = (remaining_q == 8'd1) ? IDLE : RD_REQ;
               end else begin
                  byte_idx_d = byte_idx_q + IDXW'(1);
                  rd_buf_d   = rd_buf_q >> 8;
                  tx_data_d  = 8'(rd_buf_q >> 8);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake and strobe outputs are registered images of the next state
      rx_ready_d = (state_d == IDLE) || (state_d == GET_CMD) || (state_d == GET_ADDR) ||
                   (state_d == GET_COUNT) || (state_d == GET_DATA);
      wr_en_d    = (state_d == WR_PULSE);
      rd_en_d    = (state_d == RD_REQ);
      tx_valid_d = (state_d == SEND);
   end

   always_ff @(posedge ipClk) begin
      if (reset) begin
         state_q     <= IDLE;
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         rd_buf_q    <= '0;
         remaining_q <= '0;
         byte_idx_q  <= '0;
         rx_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         rd_buf_q    <= rd_buf_d;
         remaining_q <= remaining_d;
         byte_idx_q  <= byte_idx_d;
         rx_ready_q  <= rx_ready_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
      end
   end

   assign opRxReady  = rx_ready_q;
   assign opAddress  = addr_q;
   assign opWrData   = wr_data_q;
   assign opWrEnable = wr_en_q;
   assign opRdEnable = rd_en_q;
   assign opTxData   = tx_data_q;
   assign opTxValid  = tx_valid_q;

endmodule

// File: doc/rx_reg_bridge.md
RX_REG_BRIDGE -- requirements
Module: rx_reg_bridge

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4: register width in bytes, range 1-8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: register address width, range 1-16.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'h55: packet start marker.
REQ-004 SHALL have port ipClk, input, 1: clock, all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ipRxData, input, 8: received byte.
REQ-007 SHALL have port ipRxValid, input, 1: ipRxData valid this cycle.
REQ-008 SHALL have port opRxReady, output, 1: bridge accepts a byte this cycle.
REQ-009 SHALL have port opAddress, output, ADDR_WIDTH: register address.
REQ-010 SHALL have port opWrData, output, 8*DATA_BYTES: write data.
REQ-011 SHALL have port opWrEnable, output, 1: one-cycle write strobe.
REQ-012 SHALL have port opRdEnable, output, 1: one-cycle read strobe.
REQ-013 SHALL have port ipRdData, input, 8*DATA_BYTES: read data, valid exactly 1 cycle after opRdEnable.
REQ-014 SHALL have port opTxData, output, 8: response byte.
REQ-015 SHALL have port opTxValid, output, 1: opTxData valid.
REQ-016 SHALL have port ipTxReady, input, 1: downstream accepts byte.

Function
REQ-017 SHALL accept a byte only when ipRxValid and opRxReady are both high (a "beat"); opRxReady SHALL be high only in IDLE, GET_CMD, GET_ADDR, GET_COUNT, GET_DATA.
REQ-018 SHALL use the packet format SYNC, CMD, ADDR (ceil(ADDR_WIDTH/8) bytes, LSB first), COUNT (1 byte), then for writes COUNT*DATA_BYTES data bytes, LSB first per register.
REQ-019 SHALL, in IDLE, discard non-SYNC beats and go to GET_CMD on a SYNC beat.
REQ-020 SHALL, in GET_CMD, treat 8'h01 as write, 8'h00 as read, and return to IDLE on any other value.
REQ-021 SHALL go GET_ADDR -> GET_COUNT after the last address byte; address bits above ADDR_WIDTH SHALL be ignored.
REQ-022 SHALL return to IDLE with no bus access and no response when COUNT is 0.
REQ-023 SHALL, for writes, assemble DATA_BYTES beats into opWrData, pulse opWrEnable for one cycle in the cycle after the last byte of each register, then increment opAddress.
REQ-024 SHALL, for reads, loop RD_REQ (opRdEnable for one cycle) -> RD_WAIT (capture ipRdData) -> SEND (DATA_BYTES bytes, LSB first) -> next address, COUNT times, then go to IDLE.
REQ-025 SHALL, in SEND, hold opTxData and opTxValid stable until ipTxReady is high, and advance one byte per cycle in which opTxValid and ipTxReady are both high.
REQ-026 SHALL increment the address modulo 2^ADDR_WIDTH, wrapping from all-ones to 0.
REQ-027 SHALL return to IDLE after the last write of a write burst; the next packet MAY start on the following cycle.
REQ-028 SHALL track a remaining-register counter of 8 bits and a byte index of ceil(log2(DATA_BYTES+1)) bits.
REQ-029 SHALL never assert opWrEnable and opRdEnable in the same cycle.

Reset
REQ-030 SHALL, while reset is high at a clock edge, enter IDLE and clear opRxReady, opAddress, opWrData, opWrEnable, opRdEnable, opTxData, opTxValid and all counters to 0; opRxReady SHALL rise in the first cycle after reset is released.
REQ-031 SHALL abandon any packet or burst in progress on reset, with no further strobes or transmitted bytes.

Verification
REQ-032 SHALL pass: beats 55,01,10,01,EF,BE,AD,DE -> one opWrEnable with opAddress=0x10, opWrData=0xDEADBEEF.
REQ-033 SHALL pass: beats 55,00,20,02 with ipRdData=0x11223344 at address 0x20 and 0x55667788 at 0x21 -> tx 44,33,22,11,88,77,66,55, then IDLE.
REQ-034 SHALL pass: read of 1 register with ipTxReady held low for 5 cycles mid-byte -> opTxData stable throughout, no byte lost or duplicated.
REQ-035 SHALL pass: beats 00,AA,55,07 -> no strobes, state IDLE; then a valid write packet -> one write.
REQ-036 SHALL pass: write at address 0xFF, COUNT=2 -> writes at 0xFF then 0x00.
REQ-037 SHALL pass: reset asserted during SEND of byte 2 -> opTxValid=0 the next cycle; a subsequent read packet returns correct data.
